// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver.
// Synchronizes the line, finds the start edge, samples each bit mid-period,
// optionally checks parity and delivers the word with sticky error flags.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 rx_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             PAR_ON   = (PARITY_EN != 0) ? 1'b1 : 1'b0;
  localparam logic             ODD_BIT  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Parity bit the transmitter should have sent for a given word.
  function automatic logic expected_parity(input logic [DATA_BITS-1:0] word);
    return (^word) ^ ODD_BIT;
  endfunction

  logic                 sync1_q, sync2_q;
  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 stop_bit_q, stop_bit_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 framing_err_q, framing_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 busy_q, busy_d;
  logic                 read_ack_s;

  assign rx_s = sync2_q;

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Receive FSM: start qualification, mid-bit sampling, parity and stop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    stop_bit_d = stop_bit_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Start edge is taken immediately, without waiting for a tick.
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_tick) begin
          if (cnt_q == CNT_HALF) begin
            cnt_d = CNT_ZERO;
            if (!rx_s) begin
              state_d   = S_DATA;
              idx_d     = IDX_ZERO;
              par_err_d = 1'b0;
            end else begin
              // Line went high again before mid-start: treat as a glitch.
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (cnt_q == CNT_MAX) begin
            cnt_d   = CNT_ZERO;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              idx_d   = IDX_ZERO;
              state_d = PAR_ON ? S_PARITY : S_STOP;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          if (cnt_q == CNT_MAX) begin
            cnt_d     = CNT_ZERO;
            par_err_d = (rx_s != expected_parity(shift_q));
            state_d   = S_STOP;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (cnt_q == CNT_MAX) begin
            // Re-arm half a bit early so a back-to-back start is not missed.
            cnt_d      = CNT_ZERO;
            stop_bit_d = rx_s;
            done_d     = 1'b1;
            state_d    = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
        idx_d   = IDX_ZERO;
      end
    endcase
  end

  // Delivery of completed frames, read handshake and sticky error flags.
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    framing_err_d = framing_err_q;
    parity_err_d  = parity_err_q;
    overrun_err_d = overrun_err_q;
    busy_d        = (state_d != S_IDLE);
    read_ack_s    = rx_read & rx_valid_q;
    if (done_q) begin
      // A coincident read acknowledges the old word and its flags.
      rx_data_d     = shift_q;
      rx_valid_d    = 1'b1;
      framing_err_d = (framing_err_q & ~read_ack_s) | ~stop_bit_q;
      parity_err_d  = (parity_err_q & ~read_ack_s) | par_err_q;
      overrun_err_d = (overrun_err_q & ~read_ack_s) | (rx_valid_q & ~rx_read);
    end else if (read_ack_s) begin
      rx_valid_d    = 1'b0;
      framing_err_d = 1'b0;
      parity_err_d  = 1'b0;
      overrun_err_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= CNT_ZERO;
      idx_q         <= IDX_ZERO;
      shift_q       <= {DATA_BITS{1'b0}};
      par_err_q     <= 1'b0;
      stop_bit_q    <= 1'b1;
      done_q        <= 1'b0;
      rx_data_q     <= {DATA_BITS{1'b0}};
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      par_err_q     <= par_err_d;
      stop_bit_q    <= stop_bit_d;
      done_q        <= done_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
      busy_q        <= busy_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven bench for uart_rx (8N1 and 8E1 instances).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_tick = 1'b1;
  logic       rx = 1'b1;
  logic       rx_p = 1'b1;
  logic       rd = 1'b0;
  logic       rd_p = 1'b0;

  logic [7:0] d_data, p_data;
  logic       d_valid, p_valid, d_fe, p_fe, d_pe, p_pe, d_oe, p_oe, d_busy, p_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sel;       // 0 = 8N1 instance, 1 = 8E1 instance
    logic [7:0] data;
    logic       par;       // parity bit placed on the line (sel=1 only)
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t vecs[7];

  uart_rx dut (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx(rx), .rx_read(rd),
    .rx_data(d_data), .rx_valid(d_valid), .framing_err(d_fe), .parity_err(d_pe),
    .overrun_err(d_oe), .busy(d_busy)
  );

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx(rx_p), .rx_read(rd_p),
    .rx_data(p_data), .rx_valid(p_valid), .framing_err(p_fe), .parity_err(p_pe),
    .overrun_err(p_oe), .busy(p_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame, one line bit per 16 cycles, LSB (start bit) first.
  // read_at pulses rx_read at that cycle; rst_at pulses reset_n and abandons the frame.
  task automatic drive_frame(input logic [10:0] bits, input int nbits, input logic sel,
                             input int read_at, input int rst_at);
    for (int c = 0; c < nbits * 16; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rx = 1'b1;
        rx_p = 1'b1;
        return;
      end
      if (sel) begin
        rx_p = bits[c / 16];
        rd_p = (c == read_at);
      end else begin
        rx = bits[c / 16];
        rd = (c == read_at);
      end
    end
    @(negedge clk);
    rx = 1'b1;
    rx_p = 1'b1;
    rd = 1'b0;
    rd_p = 1'b0;
  endtask

  task automatic pulse_read(input logic sel);
    @(negedge clk);
    if (sel) rd_p = 1'b1; else rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    rd_p = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] frame;
    logic [7:0]  gd;
    logic        gv, gfe, gpe, goe;

    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};

    // Reset state
    reset_n = 1'b0;
    idle(3);
    check("rst_data", {24'h0, d_data}, 32'h0);
    check("rst_valid", {31'h0, d_valid}, 32'h0);
    check("rst_flags", {28'h0, d_fe, d_pe, d_oe, d_busy}, 32'h0);
    check("rst_p_flags", {20'h0, p_data, p_valid, p_fe, p_pe, p_busy}, 32'h0);
    reset_n = 1'b1;
    idle(5);

    // Table of single frames, each followed by a read
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].sel) frame = {vecs[i].stop, vecs[i].par, vecs[i].data, 1'b0};
      else             frame = {1'b0, vecs[i].stop, vecs[i].data, 1'b0};
      drive_frame(frame, vecs[i].sel ? 11 : 10, vecs[i].sel, -1, -1);
      gd  = vecs[i].sel ? p_data  : d_data;
      gv  = vecs[i].sel ? p_valid : d_valid;
      gfe = vecs[i].sel ? p_fe    : d_fe;
      gpe = vecs[i].sel ? p_pe    : d_pe;
      goe = vecs[i].sel ? p_oe    : d_oe;
      check($sformatf("v%0d_data", i), {24'h0, gd}, {24'h0, vecs[i].exp_data});
      check($sformatf("v%0d_valid", i), {31'h0, gv}, 32'h1);
      check($sformatf("v%0d_fe", i), {31'h0, gfe}, {31'h0, vecs[i].exp_fe});
      check($sformatf("v%0d_pe", i), {31'h0, gpe}, {31'h0, vecs[i].exp_pe});
      check($sformatf("v%0d_oe", i), {31'h0, goe}, 32'h0);
      pulse_read(vecs[i].sel);
      gv  = vecs[i].sel ? p_valid : d_valid;
      gfe = vecs[i].sel ? p_fe    : d_fe;
      gpe = vecs[i].sel ? p_pe    : d_pe;
      check($sformatf("v%0d_rd_valid", i), {31'h0, gv}, 32'h0);
      check($sformatf("v%0d_rd_flags", i), {30'h0, gfe, gpe}, 32'h0);
      idle(20);
    end

    // Read while nothing is valid has no effect
    pulse_read(1'b0);
    check("idle_read", {29'h0, d_valid, d_fe, d_oe}, 32'h0);

    // Glitch: 5 cycles low, then high; back to IDLE on the 8th tick
    @(negedge clk); rx = 1'b0;
    idle(4);
    @(negedge clk); rx = 1'b1;
    idle(5);
    check("glitch_busy_hi", {31'h0, d_busy}, 32'h1);
    idle(1);
    check("glitch_busy_lo", {31'h0, d_busy}, 32'h0);
    check("glitch_valid", {30'h0, d_valid, d_fe}, 32'h0);
    idle(10);

    // Ticks held low: start is still taken, counter freezes in START
    @(negedge clk); baud_tick = 1'b0; rx = 1'b0;
    idle(40);
    check("freeze_busy", {31'h0, d_busy}, 32'h1);
    rx = 1'b1; baud_tick = 1'b1;
    idle(7);
    check("freeze_resume_busy", {31'h0, d_busy}, 32'h1);
    idle(5);
    check("freeze_end_busy", {30'h0, d_busy, d_valid}, 32'h0);
    idle(10);

    // Overrun: 0x11 then 0x22 back to back, no read
    drive_frame({1'b0, 1'b1, 8'h11, 1'b0}, 10, 1'b0, -1, -1);
    drive_frame({1'b0, 1'b1, 8'h22, 1'b0}, 10, 1'b0, -1, -1);
    check("ovr_data", {24'h0, d_data}, 32'h22);
    check("ovr_flags", {29'h0, d_valid, d_oe, d_fe}, 32'h6);
    pulse_read(1'b0);
    check("ovr_clear", {30'h0, d_valid, d_oe}, 32'h0);
    idle(20);

    // Same, with a read in the completion cycle of 0x22
    drive_frame({1'b0, 1'b1, 8'h11, 1'b0}, 10, 1'b0, -1, -1);
    drive_frame({1'b0, 1'b1, 8'h22, 1'b0}, 10, 1'b0, 155, -1);
    check("coin_data", {24'h0, d_data}, 32'h22);
    check("coin_flags", {30'h0, d_valid, d_oe}, 32'h2);
    pulse_read(1'b0);
    idle(20);

    // Reset during data bit 4, then a clean frame
    drive_frame({1'b0, 1'b1, 8'hC3, 1'b0}, 10, 1'b0, -1, 88);
    check("midrst_busy", {31'h0, d_busy}, 32'h0);
    check("midrst_valid", {31'h0, d_valid}, 32'h0);
    idle(40);
    check("midrst_after_valid", {30'h0, d_valid, d_busy}, 32'h0);
    drive_frame({1'b0, 1'b1, 8'h5A, 1'b0}, 10, 1'b0, -1, -1);
    check("post_rst_data", {24'h0, d_data}, 32'h5A);
    check("post_rst_flags", {28'h0, d_valid, d_fe, d_pe, d_oe}, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, baud_tick pulses per bit period; legal values are even numbers from 8 to 64.
REQ-003 Parameter PARITY_EN, default 0, 1 = one parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
REQ-005 clk  input  1  system clock; all logic on its rising edge; the block uses one clock only.
REQ-006 reset_n  input  1  reset, synchronous and active-low.
REQ-007 baud_tick  input  1  one-cycle oversample strobe from the baud rate generator, at OVERSAMPLE x baud.
REQ-008 rx  input  1  asynchronous serial line, idle high.
REQ-009 rx_read  input  1  one-cycle pulse; consumer has taken rx_data.
REQ-010 rx_data  output  DATA_BITS  last received word, LSB = first data bit on the line.
REQ-011 rx_valid  output  1  level; rx_data holds an unread word.
REQ-012 framing_err  output  1  sticky; a stop bit was sampled low.
REQ-013 parity_err  output  1  sticky; a parity mismatch occurred.
REQ-014 overrun_err  output  1  sticky; a word completed while rx_valid=1.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer, set to 1 on reset; the FSM SHALL use only the synchronized value rx_s.
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; a tick counter and a bit index SHALL advance only in cycles with baud_tick=1.
REQ-018 IDLE: when rx_s=0, the FSM SHALL go to START and clear the tick counter; this transition SHALL not wait for a tick.
REQ-019 START: at the OVERSAMPLE/2-th tick (counter = OVERSAMPLE/2-1), if rx_s=0 the FSM SHALL go to DATA with the counter and bit index cleared; otherwise it SHALL treat the edge as a glitch and return to IDLE with no flag set.
REQ-020 DATA: at counter = OVERSAMPLE-1, the FSM SHALL shift rx_s in from the MSB side (LSB-first reception), clear the counter and increment the bit index.
REQ-021 DATA: after the DATA_BITS-th bit, the FSM SHALL go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-022 PARITY: at counter = OVERSAMPLE-1, the FSM SHALL compare rx_s with the XOR of the data bits (inverted for odd parity), latch a mismatch flag and go to STOP.
REQ-023 STOP: at counter = OVERSAMPLE-1, the FSM SHALL sample the stop bit, complete the frame, and go to IDLE in the same cycle.
REQ-024 Frame completion SHALL, in the cycle after the stop sample:
- load rx_data from the shift register;
- set rx_valid;
- set framing_err if the stop bit was 0;
- set parity_err if the latched mismatch flag is set.
REQ-025 Frames with errors SHALL still be delivered through rx_data and rx_valid.
REQ-026 If a frame completes while rx_valid=1 and rx_read=0, the block SHALL overwrite rx_data with the new word and set overrun_err.
REQ-027 If completion and rx_read coincide, rx_valid SHALL stay 1 with the new data and overrun_err SHALL NOT set.
REQ-028 rx_read with rx_valid=1 and no completion SHALL clear rx_valid, framing_err, parity_err and overrun_err on the next edge.
REQ-029 rx_read with rx_valid=0 SHALL have no effect.
REQ-030 Sampling is mid-bit, so the FSM re-arms in IDLE about half a bit early; a start edge arriving right after the stop sample SHALL be accepted.
REQ-031 When baud_tick is held low, all counters SHALL freeze, and state SHALL change only through the IDLE to START transition.

Reset
REQ-032 While reset_n=0 at a clock edge, the block SHALL enter IDLE and clear both counters, the shift register and the parity flag.
REQ-033 While reset_n=0 at a clock edge, rx_data SHALL reset to 0 and rx_valid, framing_err, parity_err, overrun_err and busy SHALL reset to 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame without raising rx_valid.
REQ-035 After reset releases, the first falling edge on rx_s SHALL start reception.

Verification
REQ-036 Defaults, baud_tick=1 every cycle, rx sends 0xA5 framed 8N1 (16 cycles/bit) -> rx_valid=1, rx_data=0xA5, all error flags 0; rx_read -> rx_valid=0.
REQ-037 rx low for only 5 cycles, then high -> back to IDLE, rx_valid stays 0, busy drops after the 8th tick.
REQ-038 0x3C sent with stop bit 0 -> rx_data=0x3C, rx_valid=1, framing_err=1; rx_read clears both.
REQ-039 PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 1 -> parity_err=0; same byte with parity bit 0 -> parity_err=1.
REQ-040 Send 0x11 then 0x22 with no rx_read -> rx_data=0x22, overrun_err=1; repeat with rx_read pulsed in the completion cycle of 0x22 -> overrun_err=0.
REQ-041 reset_n=0 for one cycle during data bit 4 -> busy=0 and rx_valid=0; the next full frame 0x5A is received correctly.
